// File: rtl/framebuffer_scanout.sv
// Raster timing generator that scans a 1-bit-per-pixel framebuffer into a 512x256
// window, each framebuffer pixel magnified 4x4 (hires) or 8x8 (lores).
module framebuffer_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_OFFSET = 64,
   parameter int V_OFFSET = 112
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hires,
   output logic [8:0]  fb_addr,
   output logic        fb_enable,
   input  logic [15:0] fb_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pixel,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Counters are at least wide enough to hold a 512-column / 256-line window offset.
   localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
   localparam int VW = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;

   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT        = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_WIN0       = HW'(H_OFFSET);
   localparam logic [HW-1:0] H_PRE        = HW'(H_OFFSET - 4);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT        = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_WIN0       = VW'(V_OFFSET);

   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
   logic          hiresFrame;
   logic [15:0]   shiftReg;
   logic [15:0]   prefetch;
   logic          fetchDly;

   logic [HW-1:0] col;
   logic [VW-1:0] rowOff;
   logic          xIn, yIn, inWin;
   logic          loadNow, shiftNow, firstFetch, midFetch, pixBit;
   logic [2:0]    wordIdx, fetchWord;
   logic [8:0]    fetchAddr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
         hcount <= hcount + 1'b1;
      end
   end

   always_comb begin
      col        = hcount - H_WIN0;
      rowOff     = vcount - V_WIN0;
      xIn        = (hcount >= H_WIN0) && (col[HW-1:9] == '0) && (hcount < H_ACT);
      yIn        = (vcount >= V_WIN0) && (rowOff[VW-1:8] == '0) && (vcount < V_ACT);
      inWin      = xIn && yIn;
      // Next word is requested 8 clocks into the current one, well before its last pixel.
      if (hiresFrame) begin
         wordIdx  = col[8:6];
         loadNow  = inWin && (col[5:0] == 6'd0);
         shiftNow = inWin && (col[1:0] == 2'd3);
         midFetch = inWin && (col[5:0] == 6'd8) && (wordIdx != 3'd7);
      end else begin
         wordIdx  = {1'b0, col[8:7]};
         loadNow  = inWin && (col[6:0] == 7'd0);
         shiftNow = inWin && (col[2:0] == 3'd7);
         midFetch = inWin && (col[6:0] == 7'd8) && (wordIdx != 3'd3);
      end
      firstFetch = yIn && (hcount == H_PRE);
      fetchWord  = firstFetch ? 3'd0 : wordIdx + 3'd1;
      fetchAddr  = hiresFrame ? {rowOff[7:2], fetchWord}
                              : {2'b00, rowOff[7:3], fetchWord[1:0]};
      pixBit     = loadNow ? prefetch[15] : shiftReg[15];
   end

   // Read port: fb_enable is a one-cycle strobe qualifying fb_addr; the RAM answers on
   // fb_data in the following cycle, captured into prefetch via the delayed strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync      <= 1'b1;
         vsync      <= 1'b1;
         de         <= 1'b0;
         pixel      <= 1'b0;
         frame_tick <= 1'b0;
         fb_enable  <= 1'b0;
         fb_addr    <= '0;
         fetchDly   <= 1'b0;
         prefetch   <= '0;
         shiftReg   <= '0;
         hiresFrame <= 1'b0;
      end else begin
         hsync      <= !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
         vsync      <= !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
         de         <= (hcount < H_ACT) && (vcount < V_ACT);
         pixel      <= inWin && pixBit;
         frame_tick <= (hcount == '0) && (vcount == V_ACT);
         fb_enable  <= firstFetch || midFetch;
         if (firstFetch || midFetch) fb_addr <= fetchAddr;
         fetchDly   <= fb_enable;
         if (fetchDly) prefetch <= fb_data;
         if (loadNow) shiftReg <= prefetch;
         else if (shiftNow) shiftReg <= {shiftReg[14:0], 1'b0};
         if ((hcount == '0) && (vcount == '0)) hiresFrame <= hires;
      end
   end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, meaning horizontal front porch, sync and back porch in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, meaning vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameters H_OFFSET/V_OFFSET, defaults 64/112, meaning the top-left corner of the 512x256 picture window inside the active area.
REQ-006 SHALL have port clk  in  1  pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port hires  in  1  1 = 128x64 framebuffer (8 words/line), 0 = 64x32 framebuffer (4 words/line).
REQ-009 SHALL have port fb_addr  out  9  framebuffer word address (second RAM port; blitter owns the first).
REQ-010 SHALL have port fb_enable  out  1  read strobe for fb_addr.
REQ-011 SHALL have port fb_data  in  16  word read; valid the cycle after fb_addr/fb_enable are sampled; MSB is the leftmost pixel.
REQ-012 SHALL have port hsync  out  1  active-low horizontal sync.
REQ-013 SHALL have port vsync  out  1  active-low vertical sync.
REQ-014 SHALL have port de  out  1  high during the H_ACTIVE x V_ACTIVE area.
REQ-015 SHALL have port pixel  out  1  1 = lit pixel; 0 outside the picture window.
REQ-016 SHALL have port frame_tick  out  1  one-clock pulse on entering the first vertical front porch line (60 Hz timer source).

Function
REQ-017 SHALL keep hcount over 0..H_TOTAL-1 (H_TOTAL = sum of horizontal params), wrapping to 0 and then incrementing vcount over 0..V_TOTAL-1, vcount wrapping to 0.
REQ-018 SHALL register hsync low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and vsync low likewise for vcount.
REQ-019 SHALL align hsync, vsync, de and pixel: all four reflect the same hcount/vcount, one clock after the counters.
REQ-020 SHALL use scale 4 (hires) or 8 (lores): each framebuffer pixel covers scale x scale screen pixels; window = 512x256 in both modes.
REQ-021 SHALL compute row = (vcount-V_OFFSET)/scale and fetch address = row*wordsPerLine + wordIndex, 9-bit, wordIndex 0..wordsPerLine-1.
REQ-022 SHALL issue the first fetch of a window line at hcount = H_OFFSET-4 and each following fetch during the current word's display, so a word is in the prefetch register no later than 2 clocks before needed.
REQ-023 SHALL load the 16-bit shift register from the prefetch register at the window's first column and after each word's last pixel (16*scale clocks); shift MSB-first, one bit per scale clocks.
REQ-024 SHALL assert fb_enable only for the fetch cycle; no fetches outside window lines.
REQ-025 SHALL sample hires only at vcount = 0, hcount = 0; a mid-frame change takes effect next frame.
REQ-026 SHALL drive pixel = 0 whenever de = 0 or outside the window.
REQ-027 SHALL never write the framebuffer; concurrent blitter writes give per-word old-or-new data, never a corrupt word.

Reset
REQ-028 SHALL, while rst_n low, hold hcount = vcount = 0, hsync = vsync = 1, de = 0, pixel = 0, fb_enable = 0, fb_addr = 0, frame_tick = 0, shift/prefetch = 0.
REQ-029 SHALL restart from hcount = vcount = 0 on the first clock edge after rst_n rises; reset mid-line aborts any fetch without further fb_enable.

Verification
REQ-030 Timing: defaults, 2 frames -> hsync period 800 clk, low 96; vsync period 525 lines, low 2; de high 640x480; frame_tick every 420000 clk.
REQ-031 Lores pattern: fb word 0 = 16'h8001, others 0 -> pixel high at screen x 64..71 and 184..191, lines 112..119 only.
REQ-032 Hires addressing: word at address 9 = 16'hFFFF -> lit x 128..191, lines 116..119; fb_addr sequence per window line = 8 consecutive words.
REQ-033 Mode switch mid-frame: hires toggled at line 200 -> current frame unchanged; next frame uses new scale.
REQ-034 Reset mid-line: rst_n low at hcount 300 of line 150 for 3 clk -> outputs at reset values immediately; restart from 0,0; no fb_enable during reset.
REQ-035 Border: all words 16'hFFFF -> pixel high exactly within x 64..575, y 112..367; zero elsewhere, including blanking.
